dense_layer_engine: RTL and testbench

- Parametrised fully-connected layer for the DQN datapath.
- Computes y_j = act(sum_i w[i][j]*x_i + b_j) for N_OUT neurons in parallel over a streamed N_IN-element input vector.
- Weights and biases are held internally and are loadable/readable via a register port.
- Replaces the fixed 9x5 / 5x4 hand-unrolled layer logic; one instance per layer (hidden: ACT=1, output: ACT=0).

---
 rtl/dense_layer_engine_if.sv | 30 +++
 rtl/dense_layer_engine.sv | 129 ++++++++++++
 tb/tb_dense_layer_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_engine_if.sv
// Handshake and parameter-port bundle of dense_layer_engine.
// The engine uses the slave side. A producer/consumer uses the master side.
interface dense_layer_engine_if #(
  parameter int DW    = 16,
  parameter int N_OUT = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*DW-1:0]     out_data;
  logic [N_OUT-1:0]        sat_flags;
  logic                    wr_en;
  logic [15:0]             wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    wr_ready;
  logic [15:0]             rd_addr;
  logic [DW-1:0]           rd_data;

  modport master (
    output in_valid, in_data, out_ready, wr_en, wr_addr, wr_data, rd_addr,
    input  in_ready, out_valid, out_data, sat_flags, wr_ready, rd_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, wr_en, wr_addr, wr_data, rd_addr,
    output in_ready, out_valid, out_data, sat_flags, wr_ready, rd_data
  );
endinterface

// File: rtl/dense_layer_engine.sv
// Fully-connected layer: N_OUT parallel MACs over a streamed input vector.
// The layer then adds a bias, rounds, saturates and applies an optional ReLU.
module dense_layer_engine #(
  parameter int DW    = 16,
  parameter int FRAC  = 10,
  parameter int N_IN  = 9,
  parameter int N_OUT = 5,
  parameter int ACT   = 1
) (
  input logic                clk,
  input logic                rst,
  input logic                clr,
  dense_layer_engine_if.slave bus
);
  localparam int NP   = N_IN * N_OUT + N_OUT;
  localparam int AW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACCW = 2 * DW + $clog2(N_IN) + 1;

  localparam logic [15:0]             NP16 = 16'(NP);
  localparam logic [CW-1:0]           LAST = CW'(N_IN - 1);
  localparam logic signed [ACCW-1:0]  HALF = ACCW'(64'd1 << (FRAC - 1));
  localparam logic signed [ACCW-1:0]  MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0]  MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, FINISH, OUT} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic signed [DW-1:0]     prm  [NP];
  logic signed [ACCW-1:0]   acc  [N_OUT];
  logic signed [2*DW-1:0]   prod [N_OUT];
  logic signed [DW-1:0]     fin_y [N_OUT];
  logic [N_OUT-1:0]         fin_sat;
  logic signed [ACCW-1:0]   bias_ext;
  logic signed [ACCW-1:0]   zsum;
  logic signed [ACCW-1:0]   rnd;
  logic                     wr_hit;
  logic                     rd_hit;
  logic [AW-1:0]            wr_idx;
  logic [AW-1:0]            rd_idx;

  assign bus.in_ready = (state == ACCUM);
  assign bus.wr_ready = (state == ACCUM) && (cnt == '0) && !clr;
  assign wr_hit       = (bus.wr_addr < NP16);
  assign rd_hit       = (bus.rd_addr < NP16);
  assign wr_idx       = bus.wr_addr[AW-1:0];
  assign rd_idx       = bus.rd_addr[AW-1:0];

  // Per-neuron products for the current sample.
  // Also computes the rounded and saturated result used in FINISH.
  always_comb begin
    prod     = '{default: '0};
    fin_y    = '{default: '0};
    fin_sat  = '0;
    bias_ext = '0;
    zsum     = '0;
    rnd      = '0;
    for (int j = 0; j < N_OUT; j++) begin
      prod[j]  = bus.in_data * prm[AW'(int'(cnt) * N_OUT + j)];
      bias_ext = {{(ACCW-DW){prm[AW'(N_IN * N_OUT + j)][DW-1]}}, prm[AW'(N_IN * N_OUT + j)]};
      zsum     = acc[j] + (bias_ext <<< FRAC) + HALF;
      rnd      = zsum >>> FRAC;
      if (rnd > MAXV) begin
        fin_y[j]   = MAXV[DW-1:0];
        fin_sat[j] = 1'b1;
      end else if (rnd < MINV) begin
        fin_y[j]   = MINV[DW-1:0];
        fin_sat[j] = 1'b1;
      end else begin
        fin_y[j] = rnd[DW-1:0];
      end
      if (ACT != 0 && fin_y[j][DW-1]) fin_y[j] = '0;
    end
  end

  // clr outranks every other request.
  // Parameter writes land only while idle at the start of a vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ACCUM;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.sat_flags <= '0;
      bus.rd_data   <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
      for (int k = 0; k < NP; k++) prm[k] <= '0;
    end else begin
      bus.rd_data <= rd_hit ? prm[rd_idx] : '0;
      if (clr) begin
        state         <= ACCUM;
        cnt           <= '0;
        bus.out_valid <= 1'b0;
        for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (bus.wr_en && wr_hit && cnt == '0) prm[wr_idx] <= bus.wr_data;
            if (bus.in_valid) begin
              for (int j = 0; j < N_OUT; j++)
                acc[j] <= acc[j] + {{(ACCW-2*DW){prod[j][2*DW-1]}}, prod[j]};
              if (cnt == LAST) begin
                cnt   <= '0;
                state <= FINISH;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          FINISH: begin
            for (int j = 0; j < N_OUT; j++) bus.out_data[j*DW +: DW] <= fin_y[j];
            bus.sat_flags <= fin_sat;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end
          OUT: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
              state <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine.
// Two 3x2 layers (ReLU and linear) share one stimulus stream, plus one 1x3 linear layer.
module tb_dense_layer_engine;
  logic clk;
  logic rst;
  logic clr_ab;
  logic clr_c;
  int   n_cmp = 0;
  int   n_err = 0;

  dense_layer_engine_if #(.DW(16), .N_OUT(2)) ifa ();
  dense_layer_engine_if #(.DW(16), .N_OUT(2)) ifb ();
  dense_layer_engine_if #(.DW(16), .N_OUT(3)) ifc ();

  dense_layer_engine #(.DW(16), .FRAC(10), .N_IN(3), .N_OUT(2), .ACT(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_ab), .bus(ifa));
  dense_layer_engine #(.DW(16), .FRAC(10), .N_IN(3), .N_OUT(2), .ACT(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_ab), .bus(ifb));
  dense_layer_engine #(.DW(16), .FRAC(10), .N_IN(1), .N_OUT(3), .ACT(0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr_c), .bus(ifc));

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.out_ready = ifa.out_ready;
  assign ifb.wr_en     = ifa.wr_en;
  assign ifb.wr_addr   = ifa.wr_addr;
  assign ifb.wr_data   = ifa.wr_data;
  assign ifb.rd_addr   = ifa.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic writeParam(input logic [15:0] addr, input logic [15:0] data);
    ifa.wr_en   = 1'b1;
    ifa.wr_addr = addr;
    ifa.wr_data = data;
    checkOutput("wr_ready", ifa.wr_ready, 1);
    tick();
    ifa.wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    logic [15:0] xs [3];
    int n;
    xs = '{x0, x1, x2};
    for (int k = 0; k < 3; k++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = xs[k];
      n = 0;
      while (!ifa.in_ready && n < 20) begin
        tick();
        n++;
      end
      checkOutput("in_ready_wait", ifa.in_ready, 1);
      tick();
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic finishVector(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input logic [1:0] sat_a, input logic [1:0] sat_b);
    int n = 0;
    while (!ifa.out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid_a"}, ifa.out_valid, 1);
    checkOutput({tag, "_valid_b"}, ifb.out_valid, 1);
    checkOutput({tag, "_y_a"}, ifa.out_data, exp_a);
    checkOutput({tag, "_y_b"}, ifb.out_data, exp_b);
    checkOutput({tag, "_sat_a"}, ifa.sat_flags, sat_a);
    checkOutput({tag, "_sat_b"}, ifb.sat_flags, sat_b);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; clr_ab = 1'b0; clr_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = '0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.rd_addr = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", ifa.out_valid, 0);
    checkOutput("rst_out_data", ifa.out_data, 0);
    checkOutput("rst_sat", ifa.sat_flags, 0);
    checkOutput("rst_rd_data", ifa.rd_data, 0);
    checkOutput("rst_c_out_data", ifc.out_data, 0);
    rst = 1'b1;
    tick();
    checkOutput("rel_in_ready", ifa.in_ready, 1);
    checkOutput("rel_c_in_ready", ifc.in_ready, 1);

    // Unit weights and half-unit biases.
    for (int k = 0; k < 6; k++) writeParam(16'(k), 16'h0400);
    writeParam(16'd6, 16'h0200);
    writeParam(16'd7, 16'h0200);
    ifa.rd_addr = 16'd7;
    tick();
    checkOutput("rd_bias1", ifa.rd_data, 16'h0200);

    applyStimulus(16'h0400, 16'h0800, 16'hFC00);
    checkOutput("t1_valid_early", ifa.out_valid, 0);
    tick();
    tick();
    checkOutput("t1_valid_lat", ifa.out_valid, 1);
    checkOutput("t1_y_b", ifb.out_data, 32'h0A000A00);
    checkOutput("t1_sat_a", ifa.sat_flags, 0);

    // Backpressure with a sample waiting on the input.
    ifa.in_valid = 1'b1;
    ifa.in_data  = 16'h0400;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("bp_y_a", ifa.out_data, 32'h0A000A00);
      checkOutput("bp_in_ready", ifa.in_ready, 0);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    checkOutput("bp_release_ready", ifa.in_ready, 1);
    checkOutput("bp_valid_drop", ifa.out_valid, 0);
    checkOutput("bp_y_kept", ifa.out_data, 32'h0A000A00);
    tick();
    ifa.in_data = 16'h0800;
    tick();
    ifa.in_data = 16'hFC00;
    tick();
    ifa.in_valid = 1'b0;
    finishVector("t5", 32'h0A000A00, 32'h0A000A00, 2'b00, 2'b00);

    writeParam(16'd1, 16'hFC00);
    writeParam(16'd3, 16'hFC00);
    writeParam(16'd5, 16'hFC00);
    applyStimulus(16'h0400, 16'h0800, 16'hFC00);
    finishVector("t2", 32'h00000A00, 32'hFA000A00, 2'b00, 2'b00);

    for (int k = 0; k < 6; k++) writeParam(16'(k), 16'h7C00);
    applyStimulus(16'h7C00, 16'h7C00, 16'h7C00);
    finishVector("t3_pos", 32'h7FFF7FFF, 32'h7FFF7FFF, 2'b11, 2'b11);
    applyStimulus(16'h8400, 16'h8400, 16'h8400);
    finishVector("t3_neg", 32'h00000000, 32'h80008000, 2'b11, 2'b11);

    // Single-input layer: rounding half up, both sides of zero.
    ifc.wr_en = 1'b1;
    ifc.wr_addr = 16'd0; ifc.wr_data = 16'h0200; tick();
    ifc.wr_addr = 16'd1; ifc.wr_data = 16'hFE00; tick();
    ifc.wr_addr = 16'd2; ifc.wr_data = 16'hFDFF; tick();
    ifc.wr_en = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'h0001;
    checkOutput("t4_in_ready", ifc.in_ready, 1);
    tick();
    ifc.in_valid = 1'b0;
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t4_valid", ifc.out_valid, 1);
    checkOutput("t4_y", ifc.out_data, 48'hFFFF_0000_0001);
    checkOutput("t4_sat", ifc.sat_flags, 0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    for (int k = 0; k < 6; k++) writeParam(16'(k), 16'h0400);
    ifa.in_valid = 1'b1;
    ifa.in_data  = 16'h0400;
    tick();
    ifa.in_valid = 1'b0;
    ifa.wr_en = 1'b1; ifa.wr_addr = 16'd0; ifa.wr_data = 16'h0007;
    checkOutput("t6_wr_ready_busy", ifa.wr_ready, 0);
    tick();
    ifa.wr_en = 1'b0;
    ifa.rd_addr = 16'd0;
    tick();
    checkOutput("t6_rd_w00", ifa.rd_data, 16'h0400);
    ifa.rd_addr = 16'd100;
    tick();
    checkOutput("t6_rd_oob", ifa.rd_data, 16'h0000);

    ifa.in_valid = 1'b1;
    ifa.in_data  = 16'h0800;
    tick();
    ifa.in_valid = 1'b0;
    clr_ab = 1'b1;
    tick();
    clr_ab = 1'b0;
    checkOutput("t6_clr_in_ready", ifa.in_ready, 1);
    checkOutput("t6_clr_valid", ifa.out_valid, 0);
    applyStimulus(16'h0400, 16'h0800, 16'hFC00);
    finishVector("t6_clr", 32'h0A000A00, 32'h0A000A00, 2'b00, 2'b00);

    // Asynchronous reset while a result is waiting.
    applyStimulus(16'h0400, 16'h0800, 16'hFC00);
    n = 0;
    while (!ifa.out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t6_pre_rst_valid", ifa.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_rst_valid", ifa.out_valid, 0);
    checkOutput("t6_rst_y_a", ifa.out_data, 0);
    checkOutput("t6_rst_y_b", ifb.out_data, 0);
    checkOutput("t6_rst_sat", ifa.sat_flags, 0);
    rst = 1'b1;
    ifa.rd_addr = 16'd0;
    tick();
    checkOutput("t6_rst_rd_w00", ifa.rd_data, 0);
    ifa.rd_addr = 16'd6;
    tick();
    checkOutput("t6_rst_rd_b0", ifa.rd_data, 0);
    checkOutput("t6_rst_in_ready", ifa.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
